// File: rtl/dcache_pkg.sv
// Shared defaults, FSM encoding and helpers
// for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DEF_BLOCK_SIZE = 10;
  localparam int DEF_DATA_SIZE  = 32;
  localparam int DEF_INDEX_SIZE = 5;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    FILL,
    WRITE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU request/response and backing-memory bus
// of the data cache controller.
interface dcache_ctrl_if
  import dcache_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE
);

  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_we;
  logic [BLOCK_SIZE-1:0] cpu_addr;
  logic [DATA_SIZE-1:0]  cpu_wdata;
  logic                  cpu_resp_valid;
  logic [DATA_SIZE-1:0]  cpu_rdata;
  logic                  cpu_hit;

  logic [BLOCK_SIZE-1:0] mem_rdAddr;
  logic                  mem_rdEn;
  logic [BLOCK_SIZE-1:0] mem_wrAddr;
  logic [DATA_SIZE-1:0]  mem_wrData;
  logic                  mem_wrEn;
  logic [DATA_SIZE-1:0]  mem_data;

  logic [CNT_W-1:0]      hit_cnt;
  logic [CNT_W-1:0]      miss_cnt;

  modport slave (
    input  cpu_req_valid, cpu_we,
    input  cpu_addr, cpu_wdata, mem_data,
    output cpu_req_ready, cpu_resp_valid,
    output cpu_rdata, cpu_hit,
    output mem_rdAddr, mem_rdEn,
    output mem_wrAddr, mem_wrData, mem_wrEn,
    output hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req_valid, cpu_we,
    output cpu_addr, cpu_wdata, mem_data,
    input  cpu_req_ready, cpu_resp_valid,
    input  cpu_rdata, cpu_hit,
    input  mem_rdAddr, mem_rdEn,
    input  mem_wrAddr, mem_wrData, mem_wrEn,
    input  hit_cnt, miss_cnt
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data line storage: asynchronous read,
// synchronous write, valid bits cleared on reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int INDEX_SIZE = DEF_INDEX_SIZE,
  parameter int TAG_SIZE   = DEF_BLOCK_SIZE - DEF_INDEX_SIZE,
  parameter int CACHE_ROWS = 2**INDEX_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_SIZE-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_SIZE-1:0]   rd_tag_o,
  output logic [DATA_SIZE-1:0]  rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_SIZE-1:0] wr_idx_i,
  input  logic [TAG_SIZE-1:0]   wr_tag_i,
  input  logic [DATA_SIZE-1:0]  wr_data_i
);

  logic [CACHE_ROWS-1:0] valid_q;
  logic [TAG_SIZE-1:0]   tag_q  [CACHE_ROWS];
  logic [DATA_SIZE-1:0]  data_q [CACHE_ROWS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate
// data cache controller with hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int INDEX_SIZE = DEF_INDEX_SIZE,
  parameter int TAG_SIZE   = BLOCK_SIZE - INDEX_SIZE,
  parameter int CACHE_ROWS = 2**INDEX_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   lk_wait_q, lk_wait_d;
  logic   we_q, we_d;
  logic   wr_hit_q, wr_hit_d;

  logic [BLOCK_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]  wdata_q, wdata_d;

  logic                  ready_q, ready_d;
  logic                  resp_q, resp_d;
  logic [DATA_SIZE-1:0]  rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic                  rd_en_q, rd_en_d;
  logic [BLOCK_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [BLOCK_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]      hcnt_q, hcnt_d;
  logic [CNT_W-1:0]      mcnt_q, mcnt_d;

  logic [INDEX_SIZE-1:0] idx;
  logic [TAG_SIZE-1:0]   tag;
  logic                  arr_valid;
  logic [TAG_SIZE-1:0]   arr_tag;
  logic [DATA_SIZE-1:0]  arr_data;
  logic                  arr_we;
  logic [DATA_SIZE-1:0]  arr_wdata;
  logic                  lk_hit;

  assign idx    = addr_q[INDEX_SIZE-1:0];
  assign tag    = addr_q[BLOCK_SIZE-1:INDEX_SIZE];
  assign lk_hit = arr_valid && (arr_tag == tag);

  dcache_array #(
    .DATA_SIZE  (DATA_SIZE),
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE),
    .CACHE_ROWS (CACHE_ROWS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx),
    .rd_valid_o (arr_valid),
    .rd_tag_o   (arr_tag),
    .rd_data_o  (arr_data),
    .we_i       (arr_we & ~rst),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata)
  );

  always_comb begin
    state_d   = state_q;
    lk_wait_d = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_hit_d  = wr_hit_q;
    resp_d    = 1'b0;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hcnt_d    = hcnt_q;
    mcnt_d    = mcnt_q;
    arr_we    = 1'b0;
    arr_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_valid && ready_q) begin
          we_d      = bus.cpu_we;
          addr_d    = bus.cpu_addr;
          wdata_d   = bus.cpu_wdata;
          lk_wait_d = 1'b1;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        // first cycle lets the tag compare settle
        if (!lk_wait_q) begin
          if (lk_hit) hcnt_d = sat_inc(hcnt_q);
          else        mcnt_d = sat_inc(mcnt_q);
          if (we_q) begin
            arr_we    = lk_hit;
            wr_hit_d  = lk_hit;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = wdata_q;
            state_d   = WRITE;
          end else if (lk_hit) begin
            resp_d    = 1'b1;
            rdata_d   = arr_data;
            hit_d     = 1'b1;
            state_d   = IDLE;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_q;
            state_d   = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        state_d = FILL;
      end
      FILL: begin
        arr_we    = 1'b1;
        arr_wdata = bus.mem_data;
        resp_d    = 1'b1;
        rdata_d   = bus.mem_data;
        hit_d     = 1'b0;
        state_d   = IDLE;
      end
      WRITE: begin
        resp_d  = 1'b1;
        hit_d   = wr_hit_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lk_wait_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_hit_q  <= 1'b0;
      ready_q   <= 1'b0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hcnt_q    <= '0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      lk_wait_q <= lk_wait_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_hit_q  <= wr_hit_d;
      ready_q   <= ready_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hcnt_q    <= hcnt_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign bus.cpu_req_ready  = ready_q;
  assign bus.cpu_resp_valid = resp_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_hit        = hit_q;
  assign bus.mem_rdEn       = rd_en_q;
  assign bus.mem_rdAddr     = rd_addr_q;
  assign bus.mem_wrEn       = wr_en_q;
  assign bus.mem_wrAddr     = wr_addr_q;
  assign bus.mem_wrData     = wr_data_q;
  assign bus.hit_cnt        = hcnt_q;
  assign bus.miss_cnt       = mcnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-level
// cache/memory model checked every cycle.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram   [1024];
  logic [31:0] ram_m [1024];
  bit          mv [32];
  logic [4:0]  mt [32];
  logic [31:0] md [32];

  bit          chk_on = 1'b0;
  logic        e_ready, e_resp, e_hit;
  logic        e_rden, e_wren;
  logic [9:0]  e_rdaddr, e_wraddr;
  logic [31:0] e_rdata, e_wrdata;
  logic [15:0] e_hc, e_mc;

  always @(posedge clk) begin
    if (bus.mem_wrEn) ram[bus.mem_wrAddr] <= bus.mem_wrData;
    bus.mem_data <= bus.mem_rdEn ? ram[bus.mem_rdAddr]
                                 : 32'h5A5A_0F0F;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", 32'(bus.cpu_req_ready), 32'(e_ready));
      chk("resp", 32'(bus.cpu_resp_valid), 32'(e_resp));
      if (e_resp) begin
        chk("rdata", bus.cpu_rdata, e_rdata);
        chk("hit", 32'(bus.cpu_hit), 32'(e_hit));
      end
      chk("rden", 32'(bus.mem_rdEn), 32'(e_rden));
      if (e_rden) chk("rdaddr", 32'(bus.mem_rdAddr), 32'(e_rdaddr));
      chk("wren", 32'(bus.mem_wrEn), 32'(e_wren));
      if (e_wren) begin
        chk("wraddr", 32'(bus.mem_wrAddr), 32'(e_wraddr));
        chk("wrdata", bus.mem_wrData, e_wrdata);
      end
      chk("hit_cnt", 32'(bus.hit_cnt), 32'(e_hc));
      chk("miss_cnt", 32'(bus.miss_cnt), 32'(e_mc));
    end
  end

  // ab: edge (after accept) at which rst is sampled, 0 = none
  task automatic txn(input bit wr, input logic [9:0] a,
                     input logic [31:0] wd, input int ab,
                     input bit noise);
    logic [4:0] ix;
    logic [4:0] tg;
    bit         hit;
    int         lat;
    ix  = a[4:0];
    tg  = a[9:5];
    hit = mv[ix] && (mt[ix] == tg);
    lat = wr ? 3 : (hit ? 2 : 4);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_we        = wr;
    bus.cpu_addr      = a;
    bus.cpu_wdata     = wd;
    for (int j = 0; j <= lat; j++) begin
      @(posedge clk);
      #1;
      if (noise && j < lat) begin
        bus.cpu_req_valid = 1'b1;
        bus.cpu_we        = 1'b1;
        bus.cpu_addr      = 10'h3AA;
        bus.cpu_wdata     = 32'hBADBAD00;
      end else begin
        bus.cpu_req_valid = 1'b0;
      end
      if (ab != 0 && j == ab) begin
        e_ready = 1'b0;
        e_resp  = 1'b0;
        e_rden  = 1'b0;
        e_wren  = 1'b0;
        e_hc    = '0;
        e_mc    = '0;
        e_rdata = '0;
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        e_ready = 1'b1;
        return;
      end
      e_ready  = (j == lat);
      e_resp   = (j == lat);
      e_rden   = !wr && !hit && (j == 2);
      e_rdaddr = a;
      e_wren   = wr && (j == 2);
      e_wraddr = a;
      e_wrdata = wd;
      if (j == 2) begin
        if (hit) e_hc = (e_hc == 16'hFFFF) ? e_hc : e_hc + 16'd1;
        else     e_mc = (e_mc == 16'hFFFF) ? e_mc : e_mc + 16'd1;
        if (wr) begin
          ram_m[a] = wd;
          if (hit) md[ix] = wd;
        end
      end
      if (j == lat) begin
        e_hit = hit;
        if (!wr) begin
          e_rdata = hit ? md[ix] : ram_m[a];
          if (!hit) begin
            mv[ix] = 1'b1;
            mt[ix] = tg;
            md[ix] = ram_m[a];
          end
        end
      end
      if (ab != 0 && j == ab - 1) rst = 1'b1;
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_we        = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 32'h1000_0000 | 32'(i);
      ram_m[i] = 32'h1000_0000 | 32'(i);
    end
    ram[10'h025]   = 32'hDEADBEEF;
    ram_m[10'h025] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    e_ready  = 1'b0;
    e_resp   = 1'b0;
    e_hit    = 1'b0;
    e_rden   = 1'b0;
    e_wren   = 1'b0;
    e_rdaddr = '0;
    e_wraddr = '0;
    e_rdata  = '0;
    e_wrdata = '0;
    e_hc     = '0;
    e_mc     = '0;

    @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    e_ready = 1'b1;

    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("miss_data", bus.cpu_rdata, 32'hDEADBEEF);
    chk("miss_hit", 32'(bus.cpu_hit), 32'd0);

    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("rehit", 32'(bus.cpu_hit), 32'd1);
    chk("hcnt1", 32'(bus.hit_cnt), 32'd1);
    chk("mcnt1", 32'(bus.miss_cnt), 32'd1);

    txn(1'b1, 10'h025, 32'h12345678, 0, 1'b0);
    chk("wr_hit", 32'(bus.cpu_hit), 32'd1);
    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("wr_back", bus.cpu_rdata, 32'h12345678);

    txn(1'b1, 10'h045, 32'hCAFEF00D, 0, 1'b1);
    chk("wmiss_hit", 32'(bus.cpu_hit), 32'd0);
    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("kept", bus.cpu_rdata, 32'h12345678);
    chk("kept_hit", 32'(bus.cpu_hit), 32'd1);

    txn(1'b0, 10'h045, '0, 0, 1'b0);
    chk("repl_data", bus.cpu_rdata, 32'hCAFEF00D);
    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("evict_hit", 32'(bus.cpu_hit), 32'd0);
    chk("evict_data", bus.cpu_rdata, 32'h12345678);

    txn(1'b0, 10'h3FF, '0, 0, 1'b0);
    txn(1'b0, 10'h000, '0, 0, 1'b1);
    txn(1'b0, 10'h3FF, '0, 0, 1'b0);
    chk("top_data", bus.cpu_rdata, 32'h1000_03FF);
    txn(1'b1, 10'h000, 32'h0BADF00D, 0, 1'b0);
    txn(1'b0, 10'h000, '0, 0, 1'b0);
    chk("zero_data", bus.cpu_rdata, 32'h0BADF00D);

    txn(1'b0, 10'h066, '0, 3, 1'b0);
    chk("rst_resp", 32'(bus.cpu_resp_valid), 32'd0);
    txn(1'b0, 10'h066, '0, 0, 1'b0);
    chk("rst_miss", 32'(bus.cpu_hit), 32'd0);
    chk("rst_mcnt", 32'(bus.miss_cnt), 32'd1);
    chk("rst_hcnt", 32'(bus.hit_cnt), 32'd0);
    txn(1'b0, 10'h025, '0, 0, 1'b0);
    chk("rst_inval", 32'(bus.cpu_hit), 32'd0);

    @(posedge clk);
    #1;
    e_ready = 1'b1;
    e_resp  = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
